io_map_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller between the CPU data bus and the data RAM / sprite-position registers.
- Decodes each bus address into one of three regions: RAM window, N_REGS sprite/peripheral registers, or unmapped.
- Holds the registers internally with double buffering: CPU writes land in a shadow copy and are committed to the active copy on a frame-sync pulse, so the video side never sees a half-updated sprite.
- Returns read data with a fixed one-cycle latency and flags unmapped accesses.

---
 rtl/io_map_ctrl_if.sv | 25 ++
 rtl/io_map_ctrl.sv | 143 ++++++++++++++
 tb/tb_io_map_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_map_ctrl_if.sv
// Bus bundle between the CPU data port, the data RAM and io_map_ctrl.
// The master side drives requests and RAM read data; the slave side is the controller.
interface io_map_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] mem_rdata;
  logic        commit;
  logic        mem_enb;
  logic        mem_we;
  logic [31:0] rdata;
  logic        rvalid;
  logic        addr_err;

  modport master (
    output addr, wdata, we, re, mem_rdata, commit,
    input  mem_enb, mem_we, rdata, rvalid, addr_err
  );

  modport slave (
    input  addr, wdata, we, re, mem_rdata, commit,
    output mem_enb, mem_we, rdata, rvalid, addr_err
  );
endinterface

// File: rtl/io_map_ctrl.sv
// Memory-mapped I/O decode for RAM window plus double-buffered sprite registers.
// Reads answer one cycle after the request; unmapped accesses raise a one-cycle addr_err.
module io_map_ctrl #(
  parameter int unsigned MEM_TOP  = 119,
  parameter int unsigned REG_BASE = 120,
  parameter int unsigned N_REGS   = 2,
  parameter int unsigned REG_W    = 10,
  parameter logic [31:0] RST_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  io_map_ctrl_if.slave            bus,
  output logic [N_REGS-1:0]       dirty,
  output logic [N_REGS*REG_W-1:0] active_regs
);

  localparam int unsigned IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [31:0] MEM_TOP_U = 32'(MEM_TOP);
  localparam logic [31:0] REG_LO_U  = 32'(REG_BASE);
  localparam logic [32:0] REG_END   = 33'(REG_BASE) + 33'(N_REGS);
  localparam logic [REG_W-1:0] RST_V = RST_VAL[REG_W-1:0];

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_REG
  } src_e;

  logic             in_mem;
  logic             in_reg;
  logic             unmapped;
  logic [IDX_W-1:0] idx;
  logic             wr_op;
  logic             rd_op;
  logic [REG_W-1:0] wd;

  logic [REG_W-1:0] shadow_q [N_REGS];
  logic [REG_W-1:0] shadow_d [N_REGS];
  logic [REG_W-1:0] active_q [N_REGS];
  logic [REG_W-1:0] active_d [N_REGS];
  logic [N_REGS-1:0] dirty_q, dirty_d;
  src_e             src_q, src_d;
  logic [31:0]      rval_q, rval_d;
  logic             rvalid_q, rvalid_d;
  logic             aerr_q, aerr_d;

  // Address decode; the RAM window wins if it overlaps the register window.
  assign in_mem   = (bus.addr <= MEM_TOP_U);
  assign in_reg   = !in_mem && (bus.addr >= REG_LO_U) && ({1'b0, bus.addr} < REG_END);
  assign unmapped = !in_mem && !in_reg;
  assign idx      = IDX_W'(bus.addr - REG_LO_U);
  assign wd       = REG_W'(bus.wdata);

  assign wr_op = bus.we;
  assign rd_op = bus.re && !bus.we;

  assign bus.mem_enb = in_mem && (bus.we || bus.re);
  assign bus.mem_we  = in_mem && bus.we;

  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
    end
    dirty_d  = dirty_q;
    src_d    = SRC_NONE;
    rval_d   = '0;
    rvalid_d = rd_op;
    aerr_d   = (bus.we || bus.re) && unmapped;

    // Commit uses the pre-write shadow, so a same-cycle write stays pending.
    if (bus.commit) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (dirty_q[i]) begin
          active_d[i] = shadow_q[i];
          dirty_d[i]  = 1'b0;
        end
      end
    end

    if (wr_op && in_reg) begin
      shadow_d[idx] = wd;
      dirty_d[idx]  = 1'b1;
    end

    if (rd_op) begin
      if (in_mem) begin
        src_d = SRC_MEM;
      end else if (in_reg) begin
        src_d              = SRC_REG;
        rval_d[REG_W-1:0]  = shadow_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= RST_V;
        active_q[i] <= RST_V;
      end
      dirty_q  <= '0;
      src_q    <= SRC_NONE;
      rval_q   <= '0;
      rvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      dirty_q  <= dirty_d;
      src_q    <= src_d;
      rval_q   <= rval_d;
      rvalid_q <= rvalid_d;
      aerr_q   <= aerr_d;
    end
  end

  // Response stage: RAM data passes straight through in the response cycle.
  always_comb begin
    bus.rdata = '0;
    if (rvalid_q) begin
      case (src_q)
        SRC_MEM: bus.rdata = bus.mem_rdata;
        SRC_REG: bus.rdata = rval_q;
        default: bus.rdata = '0;
      endcase
    end
  end

  assign bus.rvalid   = rvalid_q;
  assign bus.addr_err = aerr_q;
  assign dirty        = dirty_q;

  always_comb begin
    active_regs = '0;
    for (int i = 0; i < N_REGS; i++) begin
      active_regs[i*REG_W +: REG_W] = active_q[i];
    end
  end

endmodule

// File: tb/tb_io_map_ctrl.sv
// Bench for io_map_ctrl: directed cycle table, randomized run against a register-file model,
// and a hand sequence on a 4x16-bit configuration.
module tb_io_map_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  io_map_ctrl_if bus_a();
  io_map_ctrl_if bus_b();
  logic [1:0]  dirty_a;
  logic [19:0] act_a;
  logic [3:0]  dirty_b;
  logic [63:0] act_b;

  io_map_ctrl dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .dirty(dirty_a), .active_regs(act_a)
  );

  io_map_ctrl #(
    .MEM_TOP(119), .REG_BASE(200), .N_REGS(4), .REG_W(16), .RST_VAL(32'h0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .dirty(dirty_b), .active_regs(act_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    bit          chk;
    bit          r, w, rd, cm;
    logic [31:0] addr, wdata, mrd;
    bit          e_enb, e_mwe, e_rv;
    logic [31:0] e_rd;
    bit          e_err;
    logic [1:0]  e_dirty;
    logic [19:0] e_act;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit chk, r, w, rd, cm, input logic [31:0] addr, wdata, mrd,
                     input bit enb, mwe, rv, input logic [31:0] rdv, input bit err,
                     input logic [1:0] dty, input logic [19:0] act);
    vec_t v;
    v.chk = chk; v.r = r; v.w = w; v.rd = rd; v.cm = cm;
    v.addr = addr; v.wdata = wdata; v.mrd = mrd;
    v.e_enb = enb; v.e_mwe = mwe; v.e_rv = rv; v.e_rd = rdv; v.e_err = err;
    v.e_dirty = dty; v.e_act = act;
    tbl.push_back(v);
  endtask

  task automatic drive_a(input bit r, w, rd, cm, input logic [31:0] ad, wd, mr);
    rst_a = r; bus_a.we = w; bus_a.re = rd; bus_a.commit = cm;
    bus_a.addr = ad; bus_a.wdata = wd; bus_a.mem_rdata = mr;
  endtask

  task automatic cyc_b(input bit r, w, rd, cm, input logic [31:0] ad, wd);
    @(negedge clk);
    rst_b = r; bus_b.we = w; bus_b.re = rd; bus_b.commit = cm;
    bus_b.addr = ad; bus_b.wdata = wd; bus_b.mem_rdata = 32'hA5A5_5A5A;
    #1;
  endtask

  // Reference model: region of an address for the default map (0=unmapped, 1=RAM, 2=register).
  function automatic int region(input logic [31:0] a);
    if (a <= 32'd119) return 1;
    if (a >= 32'd120 && a < 32'd122) return 2;
    return 0;
  endfunction

  logic [9:0]  m_sh  [2];
  logic [9:0]  m_act [2];
  bit          m_dirty [2];
  bit          p_v, p_err;
  int          p_kind;
  logic [31:0] p_val;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drive_a(1, 0, 0, 0, 0, 0, 0);
    bus_b.we = 0; bus_b.re = 0; bus_b.commit = 0;
    bus_b.addr = 0; bus_b.wdata = 0; bus_b.mem_rdata = 0;

    // Directed cycle table: expected outputs are those visible during the cycle.
    add(0,1,0,0,0,   0,      0,           0, 0,0,0,          0,0,2'b00,20'h0);
    add(1,1,0,0,0,   0,      0,           0, 0,0,0,          0,0,2'b00,20'h0);
    add(1,0,1,0,0, 120,  'h3FF,           0, 0,0,0,          0,0,2'b00,20'h0);
    add(1,0,1,0,0, 121,  'h155,           0, 0,0,0,          0,0,2'b01,20'h0);
    add(1,0,0,0,0,   0,      0,           0, 0,0,0,          0,0,2'b11,20'h0);
    add(1,0,0,0,1,   0,      0,           0, 0,0,0,          0,0,2'b11,20'h0);
    add(1,0,0,0,0,   0,      0,           0, 0,0,0,          0,0,2'b00,20'h557FF);
    add(1,0,0,1,0,  50,      0,           0, 1,0,0,          0,0,2'b00,20'h557FF);
    add(1,0,0,0,0,   0,      0,'hDEADBEEF, 0,0,1,'hDEADBEEF,0,2'b00,20'h557FF);
    add(1,0,1,0,0, 119,      5,           0, 1,1,0,          0,0,2'b00,20'h557FF);
    add(1,0,0,1,0, 121,      0,           0, 0,0,0,          0,0,2'b00,20'h557FF);
    add(1,0,0,1,0, 200,      0,     'h1234, 0,0,1,      'h155,0,2'b00,20'h557FF);
    add(1,0,0,1,0, 120,      0,     'h1234, 0,0,1,          0,1,2'b00,20'h557FF);
    add(1,0,0,0,0,   0,      0,           0, 0,0,1,      'h3FF,0,2'b00,20'h557FF);
    add(1,0,0,0,0,   0,      0,           0, 0,0,0,          0,0,2'b00,20'h557FF);
    add(1,0,1,0,0, 120,      1,           0, 0,0,0,          0,0,2'b00,20'h557FF);
    add(1,0,0,0,1,   0,      0,           0, 0,0,0,          0,0,2'b01,20'h557FF);
    add(1,0,1,0,1, 120,      2,           0, 0,0,0,          0,0,2'b00,20'h55401);
    add(1,0,0,1,0, 120,      0,           0, 0,0,0,          0,0,2'b01,20'h55401);
    add(1,0,0,0,1,   0,      0,           0, 0,0,1,          2,0,2'b01,20'h55401);
    add(1,0,1,1,0, 121,  'h2AA,           0, 0,0,0,          0,0,2'b00,20'h55402);
    add(1,0,0,0,0,   0,      0,           0, 0,0,0,          0,0,2'b10,20'h55402);
    add(1,1,0,1,0, 120,      0,           0, 0,0,0,          0,0,2'b10,20'h55402);
    add(1,0,0,0,0,   0,      0,           0, 0,0,0,          0,0,2'b00,20'h0);
    add(1,0,1,0,0, 500,      7,           0, 0,0,0,          0,0,2'b00,20'h0);
    add(1,0,0,0,0,   0,      0,           0, 0,0,0,          0,1,2'b00,20'h0);
    add(1,0,0,0,0,   0,      0,           0, 0,0,0,          0,0,2'b00,20'h0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive_a(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].cm, tbl[i].addr, tbl[i].wdata, tbl[i].mrd);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("v%0d.mem_enb", i),  64'(bus_a.mem_enb),  64'(tbl[i].e_enb));
        check($sformatf("v%0d.mem_we", i),   64'(bus_a.mem_we),   64'(tbl[i].e_mwe));
        check($sformatf("v%0d.rvalid", i),   64'(bus_a.rvalid),   64'(tbl[i].e_rv));
        check($sformatf("v%0d.rdata", i),    64'(bus_a.rdata),    64'(tbl[i].e_rd));
        check($sformatf("v%0d.addr_err", i), 64'(bus_a.addr_err), 64'(tbl[i].e_err));
        check($sformatf("v%0d.dirty", i),    64'(dirty_a),        64'(tbl[i].e_dirty));
        check($sformatf("v%0d.active", i),   64'(act_a),          64'(tbl[i].e_act));
      end
    end

    // Randomized run; the table above leaves the design in its reset-equivalent state.
    for (int i = 0; i < 2; i++) begin
      m_sh[i] = '0; m_act[i] = '0; m_dirty[i] = 0;
    end
    p_v = 0; p_err = 0; p_kind = 0; p_val = '0;

    for (int c = 0; c < 400; c++) begin
      bit          r, w, rd, cm;
      logic [31:0] ad, wd, mr, exp_rd;
      int          kind, k;
      r  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 1) == 1);
      cm = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       ad = 32'($urandom_range(0, 119));
        1:       ad = 32'(120 + $urandom_range(0, 1));
        2:       ad = 32'($urandom_range(122, 400));
        default: ad = $urandom;
      endcase
      wd = $urandom;
      mr = $urandom;
      @(negedge clk);
      drive_a(r, w, rd, cm, ad, wd, mr);
      #1;
      kind   = region(ad);
      exp_rd = !p_v ? 32'h0 : (p_kind == 1) ? mr : (p_kind == 2) ? p_val : 32'h0;
      check($sformatf("r%0d.mem_enb", c),  64'(bus_a.mem_enb),  64'(kind == 1 && (w || rd)));
      check($sformatf("r%0d.mem_we", c),   64'(bus_a.mem_we),   64'(kind == 1 && w));
      check($sformatf("r%0d.rvalid", c),   64'(bus_a.rvalid),   64'(p_v));
      check($sformatf("r%0d.rdata", c),    64'(bus_a.rdata),    64'(exp_rd));
      check($sformatf("r%0d.addr_err", c), 64'(bus_a.addr_err), 64'(p_err));
      check($sformatf("r%0d.dirty", c),    64'(dirty_a),        64'({m_dirty[1], m_dirty[0]}));
      check($sformatf("r%0d.active", c),   64'(act_a),          64'({m_act[1], m_act[0]}));

      if (r) begin
        for (int i = 0; i < 2; i++) begin
          m_sh[i] = '0; m_act[i] = '0; m_dirty[i] = 0;
        end
        p_v = 0; p_err = 0;
      end else begin
        p_v    = rd && !w;
        p_kind = kind;
        p_err  = (w || rd) && (kind == 0);
        k      = int'(ad) - 120;
        p_val  = (kind == 2) ? 32'(m_sh[k]) : 32'h0;
        if (cm) begin
          for (int i = 0; i < 2; i++) begin
            if (m_dirty[i]) begin
              m_act[i]   = m_sh[i];
              m_dirty[i] = 0;
            end
          end
        end
        if (w && kind == 2) begin
          m_sh[k]    = wd[9:0];
          m_dirty[k] = 1;
        end
      end
    end

    // Four 16-bit registers at 200..203: commit, read-back, reset against write and read.
    cyc_b(1, 0, 0, 0, 0, 0);
    cyc_b(1, 0, 0, 0, 0, 0);
    cyc_b(0, 1, 0, 0, 203, 32'hFFFF_ABCD);
    check("b.reset_dirty", 64'(dirty_b), 64'h0);
    check("b.reset_active", act_b, 64'h0);
    cyc_b(0, 0, 0, 1, 0, 0);
    check("b.write_dirty", 64'(dirty_b), 64'h8);
    check("b.precommit_active", act_b, 64'h0);
    cyc_b(0, 1, 0, 0, 202, 32'h55AA);
    check("b.commit_dirty", 64'(dirty_b), 64'h0);
    check("b.commit_active", act_b, 64'hABCD_0000_0000_0000);
    cyc_b(0, 0, 1, 0, 202, 0);
    check("b.write2_dirty", 64'(dirty_b), 64'h4);
    cyc_b(0, 0, 1, 0, 204, 0);
    check("b.raw_rvalid", 64'(bus_b.rvalid), 64'h1);
    check("b.raw_rdata", 64'(bus_b.rdata), 64'h55AA);
    check("b.raw_err", 64'(bus_b.addr_err), 64'h0);
    cyc_b(1, 1, 0, 1, 200, 32'h1234);
    check("b.unmapped_rvalid", 64'(bus_b.rvalid), 64'h1);
    check("b.unmapped_rdata", 64'(bus_b.rdata), 64'h0);
    check("b.unmapped_err", 64'(bus_b.addr_err), 64'h1);
    cyc_b(1, 0, 1, 0, 201, 0);
    check("b.rst_dirty", 64'(dirty_b), 64'h0);
    check("b.rst_active", act_b, 64'h0);
    check("b.rst_rvalid", 64'(bus_b.rvalid), 64'h0);
    check("b.rst_err", 64'(bus_b.addr_err), 64'h0);
    cyc_b(0, 0, 1, 0, 200, 0);
    check("b.rst_read_dropped", 64'(bus_b.rvalid), 64'h0);
    check("b.post_rst_active", act_b, 64'h0);
    cyc_b(0, 0, 0, 0, 0, 0);
    check("b.post_rst_rvalid", 64'(bus_b.rvalid), 64'h1);
    check("b.post_rst_rdata", 64'(bus_b.rdata), 64'h0);
    check("b.post_rst_dirty", 64'(dirty_b), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
